led_chaser_monitor: RTL
=======================

// Module: led_chaser_monitor
// PURPOSE
//  Reader side of the 8-LED one-hot chaser bus. Samples the LED pattern driven by the chaser,
//  decodes lamp position, infers shift direction and counts legal steps. Flags illegal
//  patterns and illegal jumps, and detects a stalled chaser. Used for on-board self-check of
//  the chaser and as the reference checker in chaser benches.
// PARAMETERS
//  WIDTH         8        LED bus width; must be >= 3 (rotate direction ambiguous below 3)
//  POS_W         3        position width, = clog2(WIDTH)
//  CNT_W         16       step counter width
//  STALL_CYCLES  2**20    iCLK cycles without a legal step before oSTALL asserts
// PORTS
//  iCLK      in   1       system clock; the only clock
//  iRST_N    in   1       reset, asynchronous, active-low
//  iLED      in   WIDTH   LED bus from chaser; asynchronous to monitor logic, synchronised inside
//  iCLR      in   1       sync clear: error, counter, stall; FSM back to IDLE
//  oPOS      out  POS_W   index of lit LED (0 = LSB), valid when oVALID=1
//  oVALID    out  1       1 while tracking a legal one-hot pattern
//  oDIR      out  1       direction of last legal step: 1 = toward LSB (shift right), 0 = toward MSB
//  oSTEP     out  1       one-cycle pulse per legal step
//  oSTEPS    out  CNT_W   legal step count, saturating at all-ones
//  oERR      out  1       sticky fault flag
//  oSTALL    out  1       no legal step for STALL_CYCLES cycles while tracking
// BEHAVIOUR
//  - Reset (iRST_N=0, async): all outputs 0, FSM=IDLE, sync regs and prev pattern = 0.
//  - Input path: 2-flop synchroniser on iLED -> s; prev holds s of previous cycle.
//    iLED change at edge N appears on oSTEP/oPOS after edge N+3 (3-cycle latency).
//  - onehot(s): exactly one bit set. rotr(x) = {x[0], x[WIDTH-1:1]}, rotl(x) = {x[WIDTH-2:0], x[WIDTH-1]}.
//  - FSM IDLE: s one-hot -> TRACK, oVALID=1, oPOS=index(s), no oSTEP, no count.
//               s not one-hot (zero or multi-hot) -> stay IDLE, no error.
//  - FSM TRACK: s==prev -> hold, stall counter +1.
//               s==rotr(prev) -> oSTEP=1, oDIR=1, oPOS updated, oSTEPS+1, stall counter cleared.
//               s==rotl(prev) -> same, but oDIR=0.
//               any other s (zero, multi-hot, jump >1 position) -> FAULT.
//    Wrap is legal: 0x01->0x80 is a right step, 0x80->0x01 is a left step.
//  - FSM FAULT: oERR=1, oVALID=0, oSTEP=0, oPOS holds last legal value; stays until iCLR.
//  - Stall: counter counts TRACK cycles since the last legal step (or since TRACK entry).
//    Reaching STALL_CYCLES sets oSTALL=1, and the counter saturates. The next legal step clears
//    oSTALL in the same cycle that oSTEP pulses. oSTALL is forced 0 outside TRACK.
//  - oSTEPS saturates at 2**CNT_W-1; further steps still pulse oSTEP.
//  - iCLR (sync, 1 cycle): oERR=0, oSTEPS=0, oSTALL=0, stall counter=0, FSM=IDLE, oVALID=0.
//    iCLR has priority over a coincident step: the step is dropped, no oSTEP, no count.
//  - Reset mid-operation: immediate return to reset values. The first one-hot sample after
//    release re-enters TRACK without a step.
//  - Direction change (right then left) is legal. oDIR follows each step.
// TESTING (STALL_CYCLES=16 for sim)
//  1 reset release, iLED=0x01 -> after 3 clk oVALID=1, oPOS=0, oSTEP=0, oSTEPS=0
//  2 iLED 0x01->0x80->0x40 -> two oSTEP pulses, oDIR=1, oPOS=7 then 6, oSTEPS=2
//  3 iLED 0x80->0x01->0x02 -> oDIR=0, oPOS=0 then 1, two pulses, no oERR
//  4 iLED 0x04->0x20 (jump), or 0x04->0x0C -> oERR=1, oVALID=0; iCLR -> oERR=0, oSTEPS=0, IDLE
//  5 iLED held 0x08 for 20 clk -> oSTALL=1 from the 16th TRACK cycle; step to 0x10 -> oSTALL=0, oSTEP=1
//  6 iCLR coincident with a step, and iRST_N=0 mid-tracking -> no oSTEP, outputs at reset/clear values

Source files
------------

// File: rtl/led_chaser_monitor.sv
// Reader/checker for the one-hot LED chaser bus: tracks lamp position and step direction,
// counts legal steps, and flags illegal patterns, illegal jumps and a stalled chaser.
module led_chaser_monitor #(
  parameter int WIDTH        = 8,
  parameter int POS_W        = $clog2(WIDTH),
  parameter int CNT_W        = 16,
  parameter int STALL_CYCLES = 2**20
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [WIDTH-1:0] iLED,
  input  logic             iCLR,
  output logic [POS_W-1:0] oPOS,
  output logic             oVALID,
  output logic             oDIR,
  output logic             oSTEP,
  output logic [CNT_W-1:0] oSTEPS,
  output logic             oERR,
  output logic             oSTALL
);

  // state | meaning
  // IDLE  | waiting for a one-hot sample to lock onto
  // TRACK | following legal single-position steps
  // FAULT | illegal pattern or jump seen; sticky until iCLR
  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_FAULT} state_t;

  localparam int              SC_W      = $clog2(STALL_CYCLES + 1);
  localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_CYCLES);

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_sync1, r_s, r_prev;
  logic [SC_W-1:0]    r_cnt, w_cnt_nx;
  logic [POS_W-1:0]   r_pos, w_pos_nx, w_idx;
  logic [CNT_W-1:0]   r_steps, w_steps_nx;
  logic               r_valid, w_valid_nx;
  logic               r_dir, w_dir_nx;
  logic               r_step, w_step_nx;
  logic               r_err, w_err_nx;
  logic               r_stall, w_stall_nx;
  logic               w_onehot;
  logic [WIDTH-1:0]   w_rotr, w_rotl;
  logic [CNT_W-1:0]   w_steps_inc;

  assign w_onehot    = (r_s != '0) && ((r_s & (r_s - WIDTH'(1))) == '0);
  assign w_rotr      = {r_prev[0], r_prev[WIDTH-1:1]};
  assign w_rotl      = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
  assign w_steps_inc = (r_steps == '1) ? r_steps : r_steps + CNT_W'(1);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (r_s[i]) w_idx = POS_W'(i);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= '0;
      r_s     <= '0;
      r_prev  <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_steps <= '0;
      r_valid <= 1'b0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_sync1 <= iLED;
      r_s     <= r_sync1;
      r_prev  <= r_s;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pos   <= w_pos_nx;
      r_steps <= w_steps_nx;
      r_valid <= w_valid_nx;
      r_dir   <= w_dir_nx;
      r_step  <= w_step_nx;
      r_err   <= w_err_nx;
      r_stall <= w_stall_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pos_nx   = r_pos;
    w_steps_nx = r_steps;
    w_valid_nx = r_valid;
    w_dir_nx   = r_dir;
    w_step_nx  = 1'b0;
    w_err_nx   = r_err;
    w_stall_nx = 1'b0;
    if (iCLR) begin
      // clear wins over any step decided this cycle
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
      w_steps_nx = '0;
      w_valid_nx = 1'b0;
      w_err_nx   = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_valid_nx = 1'b0;
          if (w_onehot) begin
            w_state_nx = ST_TRACK;
            w_valid_nx = 1'b1;
            w_pos_nx   = w_idx;
            w_cnt_nx   = '0;
          end
        end
        ST_TRACK: begin
          if (r_s == r_prev) begin
            w_cnt_nx   = (r_cnt == STALL_MAX) ? r_cnt : r_cnt + SC_W'(1);
            w_stall_nx = (w_cnt_nx == STALL_MAX);
          end else if (r_s == w_rotr || r_s == w_rotl) begin
            w_step_nx  = 1'b1;
            w_dir_nx   = (r_s == w_rotr);
            w_pos_nx   = w_idx;
            w_steps_nx = w_steps_inc;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = ST_FAULT;
            w_err_nx   = 1'b1;
            w_valid_nx = 1'b0;
            w_cnt_nx   = '0;
          end
        end
        ST_FAULT: begin
          w_err_nx   = 1'b1;
          w_valid_nx = 1'b0;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  assign oPOS   = r_pos;
  assign oVALID = r_valid;
  assign oDIR   = r_dir;
  assign oSTEP  = r_step;
  assign oSTEPS = r_steps;
  assign oERR   = r_err;
  assign oSTALL = r_stall;

endmodule
